// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// spi_arbiter : round-robin arbiter sharing one SPI transmitter among four
// requesters. Optional timeout feature: define SPI_ARBITER_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
module spi_arbiter #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] ckp_cfg,
  input  logic [3:0] cph_cfg,
  input  logic       CS,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       trans,
  output logic       CKP,
  output logic       CPH,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_START        = 3'd1,
    S_WAIT_CS_LOW  = 3'd2,
    S_WAIT_CS_HIGH = 3'd3,
    S_GAP          = 3'd4
  } state_t;

  localparam logic [7:0] c_GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     r_state, w_state_next;
  logic [3:0] r_gnt, w_gnt_next;
  logic [3:0] r_done, w_done_next;
  logic       r_ckp, w_ckp_next;
  logic       r_cph, w_cph_next;
  logic [1:0] r_last, w_last_next;
  logic [7:0] r_gap, w_gap_next;
  logic       w_found;
  logic [1:0] w_win;
  logic       w_to_hit;
  logic       w_waiting;

  assign w_waiting = (r_state == S_WAIT_CS_LOW) || (r_state == S_WAIT_CS_HIGH);

  // Search upward from the requester after the last winner, wrapping mod 4.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && req[2'(int'(r_last) + 1 + k)]) begin
        w_found = 1'b1;
        w_win   = 2'(int'(r_last) + 1 + k);
      end
    end
  end

`ifdef SPI_ARBITER_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 2);

  logic [15:0] r_tcnt;
  logic        r_tout;

  // Counter is zero throughout START; it reaches c_TO_LAST on the cycle
  // before the TIMEOUT_CYCLES-th cycle after START begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_tout <= 1'b0;
    end else begin
      r_tout <= w_to_hit;
      if (r_state == S_IDLE) begin
        r_tcnt <= '0;
      end else if (w_waiting) begin
        r_tcnt <= r_tcnt + 16'd1;
      end
    end
  end

  assign w_to_hit    = w_waiting && (r_tcnt == c_TO_LAST);
  assign timeout_err = r_tout;
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_to_hit         = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = r_gnt;
    w_done_next  = 4'b0000;
    w_ckp_next   = r_ckp;
    w_cph_next   = r_cph;
    w_last_next  = r_last;
    w_gap_next   = r_gap;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next = S_START;
          w_gnt_next   = 4'b0001 << w_win;
          w_ckp_next   = ckp_cfg[w_win];
          w_cph_next   = cph_cfg[w_win];
          w_last_next  = w_win;
        end
      end
      S_START: begin
        w_state_next = S_WAIT_CS_LOW;
      end
      S_WAIT_CS_LOW: begin
        if (w_to_hit) begin
          w_state_next = S_GAP;
          w_gnt_next   = 4'b0000;
          w_gap_next   = c_GAP_LAST;
        end else if (!CS) begin
          w_state_next = S_WAIT_CS_HIGH;
        end
      end
      S_WAIT_CS_HIGH: begin
        if (w_to_hit) begin
          w_state_next = S_GAP;
          w_gnt_next   = 4'b0000;
          w_gap_next   = c_GAP_LAST;
        end else if (CS) begin
          w_state_next = S_GAP;
          w_done_next  = r_gnt;
          w_gnt_next   = 4'b0000;
          w_gap_next   = c_GAP_LAST;
        end
      end
      S_GAP: begin
        if (r_gap == 8'd0) begin
          w_state_next = S_IDLE;
        end else begin
          w_gap_next = r_gap - 8'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_gnt_next   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 4'b0000;
      r_done  <= 4'b0000;
      r_ckp   <= 1'b0;
      r_cph   <= 1'b0;
      r_last  <= 2'd3;
      r_gap   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_done  <= w_done_next;
      r_ckp   <= w_ckp_next;
      r_cph   <= w_cph_next;
      r_last  <= w_last_next;
      r_gap   <= w_gap_next;
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign CKP   = r_ckp;
  assign CPH   = r_cph;
  assign trans = (r_state == S_START) || (r_state == S_WAIT_CS_LOW);
  assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 4: idle clock cycles enforced between consecutive transactions (legal range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: cycle limit for one transaction when the timeout feature is compiled in (legal range 2..65535).
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  per-requester transaction request, level-sensitive.
REQ-006 ckp_cfg  input  4  per-requester SPI clock polarity.
REQ-007 cph_cfg  input  4  per-requester SPI clock phase.
REQ-008 CS  input  1  chip select from the SPI transmitter, active-low; low means a transaction is in progress.
REQ-009 gnt  output  4  one-hot grant; at most one bit high.
REQ-010 done  output  4  one-cycle completion pulse to the granted requester.
REQ-011 trans  output  1  transaction-start level to the transmitter.
REQ-012 CKP  output  1  registered polarity forwarded to transmitter and receivers.
REQ-013 CPH  output  1  registered phase forwarded to transmitter and receivers.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 timeout_err  output  1  one-cycle timeout pulse.

Function
REQ-016 FSM states: IDLE, START, WAIT_CS_LOW, WAIT_CS_HIGH, GAP; state is registered.
REQ-017 IDLE, any req bit high: round-robin selection, searching upward from (last_grant+1) mod 4.
- In the next cycle: gnt bit set, CKP/CPH loaded from the winner's cfg bits, state -> START.
REQ-018 START lasts exactly one cycle with trans=1, then state -> WAIT_CS_LOW.
REQ-019 WAIT_CS_LOW: trans held 1.
- First cycle CS is sampled low: trans=0 from the next cycle, state -> WAIT_CS_HIGH.
REQ-020 WAIT_CS_HIGH, first cycle CS is sampled high: done bit for the granted requester pulses for exactly one cycle, gnt clears in the same cycle, state -> GAP.
REQ-021 GAP holds for exactly GAP_CYCLES cycles, then state -> IDLE; requests are not evaluated during GAP.
REQ-022 CKP and CPH remain stable from grant until the next grant; they never change while CS is low.
REQ-023 last_grant updates only on a grant.
REQ-024 A granted requester dropping req mid-transaction is ignored; the transaction completes and done still pulses.
REQ-025 Requests held through GAP are served in round-robin order; no requester is granted twice while another holds req continuously.
REQ-026 CS already low on entry to WAIT_CS_LOW is treated as the transmitter having started; no deadlock results.
REQ-027 Minimum transaction overhead: grant-to-trans 1 cycle; done-to-next-gnt GAP_CYCLES+1 cycles.

Reset
REQ-028 While Reset is low, all outputs are forced immediately (asynchronously) to: gnt=0, done=0, trans=0, CKP=0, CPH=0, busy=0, timeout_err=0; state=IDLE; last_grant=3 (requester 0 wins first).
REQ-029 Reset asserted mid-transaction aborts with no done pulse; a transaction left running by the transmitter is not tracked after release.
REQ-030 Reset deassertion takes effect on the next CLK rising edge.

Configuration
REQ-031 Macro SPI_ARBITER_TIMEOUT_EN defined: a counter clears on entering START and increments in WAIT_CS_LOW/WAIT_CS_HIGH.
- On reaching TIMEOUT_CYCLES: timeout_err pulses one cycle, trans=0, gnt clears, no done pulse, state -> GAP.
REQ-032 Macro undefined: no counter is built, timeout_err is tied 0, and the FSM waits on CS indefinitely.

Verification
REQ-033 req=0001, cfg ckp=0001/cph=0000: gnt=0001 one cycle later, CKP=1, trans high until CS low, done=0001 one cycle after CS rises.
REQ-034 req=1111 held: grant order 0,1,2,3,0; each done separated from the next gnt by 5 cycles (GAP_CYCLES=4).
REQ-035 req[2] dropped after grant: the transaction completes, done=0100 pulses, then the next requester is served.
REQ-036 Reset pulled low while CS is low in WAIT_CS_HIGH: all outputs 0 immediately; after release with req=0010, requester 1 is granted.
REQ-037 With SPI_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=16, CS held high: timeout_err pulses 16 cycles after START, done stays 0, busy low after GAP.
REQ-038 CKP/CPH change on cfg inputs while CS is low: outputs unchanged until the next grant.
